// File: rtl/rotor_pkg.sv
// rtl/rotor_pkg.sv - shared rotor parameters and FSM state encoding
package rotor_pkg;

    localparam int DEF_NUM_ROTORS = 8;
    localparam int DEF_ALPHA      = 26;
    localparam int DEF_POS_W      = 5;
    localparam int IDX_W          = 3;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_STEP = 1'b1;

endpackage

// File: rtl/rotor_pos_incdec.sv
// rtl/rotor_pos_incdec.sv - modulo-ALPHA +/-1 of one rotor position with wrap flag
module rotor_pos_incdec #(
    parameter int ALPHA = 26,
    parameter int POS_W = 5
) (
    input  logic [POS_W-1:0] pos,
    input  logic             dir,
    output logic [POS_W-1:0] pos_next,
    output logic             wrap
);

    localparam logic [POS_W-1:0] MAX_POS = POS_W'(ALPHA - 1);

    always_comb begin
        if (dir) begin
            wrap     = (pos == MAX_POS);
            pos_next = wrap ? '0 : pos + POS_W'(1);
        end else begin
            wrap     = (pos == '0);
            pos_next = wrap ? MAX_POS : pos - POS_W'(1);
        end
    end

endmodule

// File: rtl/rotor_config_ctrl.sv
// rtl/rotor_config_ctrl.sv - rotor position registers arbitrated between user edits and odometer stepping
module rotor_config_ctrl
    import rotor_pkg::*;
#(
    parameter int NUM_ROTORS = DEF_NUM_ROTORS,
    parameter int ALPHA      = DEF_ALPHA,
    parameter int POS_W      = DEF_POS_W
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_ROTORS-1:0]       sel_press,
    input  logic                        enc_step,
    input  logic                        enc_dir,
    input  logic                        edit_lock,
    input  logic                        step_req,
    output logic                        step_busy,
    output logic                        step_done,
    output logic                        sel_valid,
    output logic [IDX_W-1:0]            sel_idx,
    output logic [NUM_ROTORS*POS_W-1:0] rotor_pos
);

    logic [POS_W-1:0] pos_q [NUM_ROTORS];
    logic [POS_W-1:0] pos_d [NUM_ROTORS];
    logic             state_q, state_d;
    logic [IDX_W-1:0] cursor_q, cursor_d;
    logic             step_done_q, step_done_d;
    logic             sel_valid_q, sel_valid_d;
    logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
    logic             pending_q, pending_d;
    logic             pending_dir_q, pending_dir_d;

    logic             edit_go;
    logic             wr_en;
    logic [IDX_W-1:0] op_idx;
    logic             op_dir;
    logic [POS_W-1:0] op_next;
    logic             op_wrap;
    logic [IDX_W-1:0] press_idx;

    // The single inc/dec unit is shared: STEP owns it, otherwise the edit path does.
    assign edit_go = (enc_step || pending_q) && sel_valid_q && !edit_lock;
    assign op_idx  = (state_q == ST_STEP) ? cursor_q : sel_idx_q;
    assign op_dir  = (state_q == ST_STEP) ? 1'b1 : (enc_step ? enc_dir : pending_dir_q);

    rotor_pos_incdec #(.ALPHA(ALPHA), .POS_W(POS_W)) u_incdec (
        .pos      (pos_q[op_idx]),
        .dir      (op_dir),
        .pos_next (op_next),
        .wrap     (op_wrap)
    );

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        step_done_d = 1'b0;
        wr_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (step_req) begin
                    state_d  = ST_STEP;
                    cursor_d = '0;
                end else if (edit_go) begin
                    wr_en = 1'b1;
                end
            end
            default: begin
                wr_en = 1'b1;
                if (op_wrap && cursor_q != IDX_W'(NUM_ROTORS - 1)) begin
                    cursor_d = cursor_q + IDX_W'(1);
                end else begin
                    step_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cursor_q    <= '0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            step_done_q <= step_done_d;
        end
    end

    always_comb begin
        step_busy = (state_q == ST_STEP);
        step_done = step_done_q;
        sel_valid = sel_valid_q;
        sel_idx   = sel_idx_q;
        rotor_pos = '0;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            rotor_pos[i*POS_W +: POS_W] = pos_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ROTORS; i++) begin
            pos_d[i] = pos_q[i];
        end
        if (wr_en) begin
            pos_d[op_idx] = op_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
                pos_q[i] <= pos_d[i];
            end
        end
    end

    always_comb begin
        press_idx = '0;
        for (int i = NUM_ROTORS - 1; i >= 0; i--) begin
            if (sel_press[i]) begin
                press_idx = IDX_W'(i);
            end
        end
        sel_valid_d = sel_valid_q;
        sel_idx_d   = sel_idx_q;
        if (sel_press != '0 && !edit_lock) begin
            if (sel_valid_q && press_idx == sel_idx_q) begin
                sel_valid_d = 1'b0;
            end else begin
                sel_valid_d = 1'b1;
                sel_idx_d   = press_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_valid_q <= 1'b0;
            sel_idx_q   <= '0;
        end else begin
            sel_valid_q <= sel_valid_d;
            sel_idx_q   <= sel_idx_d;
        end
    end

    // Pending is consumed by the first IDLE cycle that the step path does not claim.
    always_comb begin
        pending_d     = pending_q;
        pending_dir_d = pending_dir_q;
        if (state_q == ST_IDLE && !step_req) begin
            pending_d = 1'b0;
        end else if (enc_step && sel_valid_q && !edit_lock) begin
            pending_d     = 1'b1;
            pending_dir_d = enc_dir;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q     <= 1'b0;
            pending_dir_q <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            pending_dir_q <= pending_dir_d;
        end
    end

endmodule

// File: tb/tb_rotor_config_ctrl.sv
// tb/tb_rotor_config_ctrl.sv - directed self-checking bench for rotor_config_ctrl
module tb_rotor_config_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  sel_press;
    logic        enc_step;
    logic        enc_dir;
    logic        edit_lock;
    logic        step_req;
    logic        step_busy;
    logic        step_done;
    logic        sel_valid;
    logic [2:0]  sel_idx;
    logic [39:0] rotor_pos;

    int checks = 0;
    int errors = 0;

    rotor_config_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sel_press (sel_press),
        .enc_step  (enc_step),
        .enc_dir   (enc_dir),
        .edit_lock (edit_lock),
        .step_req  (step_req),
        .step_busy (step_busy),
        .step_done (step_done),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx),
        .rotor_pos (rotor_pos)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        assert (!(reset_n && step_req && step_busy))
            else $error("step_req issued while step_busy");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [7:0] mask);
        sel_press = mask;
        tick();
        sel_press = '0;
    endtask

    task automatic enc(input logic dir, input int n);
        for (int i = 0; i < n; i++) begin
            enc_step = 1'b1;
            enc_dir  = dir;
            tick();
            enc_step = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    int  busy_cnt;
    bit  done_seen;

    initial begin
        reset_n   = 1'b0;
        sel_press = '0;
        enc_step  = 1'b0;
        enc_dir   = 1'b0;
        edit_lock = 1'b0;
        step_req  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // 1 reset state
        check_eq("reset_rotor_pos", rotor_pos, 40'h0);
        check_eq("reset_sel_valid", sel_valid, 1'b0);
        check_eq("reset_sel_idx",   sel_idx,   3'd0);
        check_eq("reset_step_busy", step_busy, 1'b0);
        check_eq("reset_step_done", step_done, 1'b0);

        // 2 edit + wrap
        press(8'h04);
        check_eq("sel_valid_r2", sel_valid, 1'b1);
        check_eq("sel_idx_r2",   sel_idx,   3'd2);
        enc(1'b1, 3);
        check_eq("edit_up3", rotor_pos, 40'd3 << 10);
        enc(1'b0, 4);
        check_eq("edit_down_wrap", rotor_pos, 40'd25 << 10);

        // 3 toggle / lowest-bit priority / drop without selection
        press(8'h04);
        check_eq("deselect", sel_valid, 1'b0);
        enc(1'b1, 1);
        check_eq("drop_no_sel", rotor_pos, 40'd25 << 10);
        press(8'h04);
        press(8'h04);
        check_eq("press_twice", sel_valid, 1'b0);
        press(8'h0A);
        check_eq("prio_valid", sel_valid, 1'b1);
        check_eq("prio_idx",   sel_idx,   3'd1);
        enc(1'b1, 1);
        check_eq("edit_rotor1", rotor_pos, (40'd25 << 10) | (40'd1 << 5));

        // 4 ripple
        do_reset();
        for (int i = 0; i < 3; i++) begin
            press(8'(1 << i));
            enc(1'b0, 1);
        end
        press(8'h08);
        enc(1'b1, 7);
        check_eq("ripple_setup", rotor_pos, (40'd7 << 15) | (40'd25 << 10) | (40'd25 << 5) | 40'd25);
        step_req = 1'b1;
        tick();
        step_req  = 1'b0;
        busy_cnt  = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (step_busy) busy_cnt++;
            if (step_done) begin
                done_seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("ripple_done_seen", done_seen, 1'b1);
        check_eq("ripple_busy_cycles", busy_cnt, 4);
        check_eq("ripple_result", rotor_pos, 40'd8 << 15);
        tick();
        check_eq("done_one_cycle", step_done, 1'b0);

        // 5 collision of step_req and enc_step
        press(8'h20);
        enc(1'b1, 10);
        check_eq("coll_setup", rotor_pos, (40'd10 << 25) | (40'd8 << 15));
        step_req = 1'b1;
        enc_step = 1'b1;
        enc_dir  = 1'b1;
        tick();
        step_req = 1'b0;
        enc_step = 1'b0;
        check_eq("coll_busy", step_busy, 1'b1);
        tick();
        check_eq("coll_done", step_done, 1'b1);
        check_eq("coll_step_first", rotor_pos, (40'd10 << 25) | (40'd8 << 15) | 40'd1);
        tick();
        check_eq("coll_pending_applied", rotor_pos, (40'd11 << 25) | (40'd8 << 15) | 40'd1);

        // 6 lock
        edit_lock = 1'b1;
        press(8'h01);
        check_eq("lock_sel_valid", sel_valid, 1'b1);
        check_eq("lock_sel_idx",   sel_idx,   3'd5);
        enc(1'b1, 1);
        check_eq("lock_no_edit", rotor_pos, (40'd11 << 25) | (40'd8 << 15) | 40'd1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        check_eq("lock_step_done", step_done, 1'b1);
        check_eq("lock_step_pos", rotor_pos, (40'd11 << 25) | (40'd8 << 15) | 40'd2);
        edit_lock = 1'b0;
        tick();
        check_eq("lock_no_pending", rotor_pos, (40'd11 << 25) | (40'd8 << 15) | 40'd2);

        // 1b reset in the middle of a ripple
        do_reset();
        press(8'h01);
        enc(1'b0, 1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        check_eq("mid_busy", step_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_reset_busy", step_busy, 1'b0);
        check_eq("mid_reset_pos",  rotor_pos, 40'h0);
        tick();
        reset_n   = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (step_done) done_seen = 1'b1;
        end
        check_eq("mid_reset_no_done", done_seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
